// File: rtl/video_capture_downscaler_if.sv
`default_nettype none
// ============================================================================
// Module   : video_capture_downscaler_if
// Purpose  : Video input (vsync/de/rgb) and FIFO write-side bundle for the
//            capture downscaler.
// Revision : 1.0 - initial release
// ============================================================================
interface video_capture_downscaler_if;
    logic        vsync;
    logic        de;
    logic [23:0] rgb_data;
    logic        fifo_full;
    logic [15:0] pixel_data;
    logic        wr_enable;

    modport master (
        output vsync, de, rgb_data, fifo_full,
        input  pixel_data, wr_enable
    );

    modport slave (
        input  vsync, de, rgb_data, fifo_full,
        output pixel_data, wr_enable
    );
endinterface
`default_nettype wire

// File: rtl/video_capture_downscaler.sv
`default_nettype none
// ============================================================================
// Module   : video_capture_downscaler
// Purpose  : 2x2 downscale of an RGB888 capture stream to RGB565 FIFO writes.
//            Define BOX_FILTER_EN for 2x2 box averaging instead of decimation.
// Revision : 1.0 - initial release
// ============================================================================
module video_capture_downscaler #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic                      clk,
    input  logic                      rst,
    video_capture_downscaler_if.slave vid,
    output logic                      frame_start_pulse,
    output logic [9:0]                o_x_count,
    output logic [8:0]                o_y_count,
    output logic                      overflow,
    output logic                      line_err
);
    localparam logic [9:0] C_H_MAX = 10'(H_ACTIVE);
    localparam logic [8:0] C_V_MAX = 9'(V_ACTIVE);

    typedef enum logic [0:0] {
        SYNC_WAIT = 1'b0,
        ACTIVE    = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_vsync_d;
    logic        r_de_d;
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic        r_wr_en;
    logic [15:0] r_pixel;
    logic        r_fsp;
    logic        r_overflow;
    logic        r_line_err;

    logic        w_vsync_fall;
    logic        w_pix_accept;
    logic        w_slot;
    logic [23:0] w_out_rgb;
    logic [15:0] w_packed;
    logic        w_unused_lsbs;

    assign w_vsync_fall = r_vsync_d & ~vid.vsync;
    // A vsync edge takes priority over any pixel presented in the same cycle.
    assign w_pix_accept = (r_state == ACTIVE) & ~w_vsync_fall & vid.de
                        & (r_x < C_H_MAX) & (r_y < C_V_MAX);
    assign w_slot       = w_pix_accept & r_x[0] & r_y[0];

`ifdef BOX_FILTER_EN
    localparam int C_LB_DEPTH = H_ACTIVE / 2;
    localparam int C_LB_AW    = (C_LB_DEPTH > 1) ? $clog2(C_LB_DEPTH) : 1;

    logic [23:0]        r_pair;
    logic [26:0]        r_line_buf [C_LB_DEPTH];
    logic [C_LB_AW-1:0] w_lb_addr;
    logic [26:0]        w_pair_sum;
    logic [26:0]        w_lb_rd;

    assign w_lb_addr = r_x[C_LB_AW:1];
    assign w_lb_rd   = r_line_buf[w_lb_addr];

    // Per channel: 9-bit horizontal pair sum, plus the even-line pair sum -> 10 bits.
    for (genvar c = 0; c < 3; c++) begin : g_ch
        logic [9:0] w_blk_sum;
        logic [1:0] w_unused_frac;
        assign w_pair_sum[c*9 +: 9] = {1'b0, r_pair[c*8 +: 8]} + {1'b0, vid.rgb_data[c*8 +: 8]};
        assign w_blk_sum            = {1'b0, w_pair_sum[c*9 +: 9]} + {1'b0, w_lb_rd[c*9 +: 9]};
        assign w_out_rgb[c*8 +: 8]  = w_blk_sum[9:2];
        assign w_unused_frac        = w_blk_sum[1:0];
    end

    always_ff @(posedge clk) begin
        if (w_pix_accept) begin
            if (!r_x[0]) begin
                r_pair <= vid.rgb_data;
            end else if (!r_y[0]) begin
                r_line_buf[w_lb_addr] <= w_pair_sum;
            end
        end
    end
`else
    assign w_out_rgb = vid.rgb_data;
`endif

    assign w_packed      = {w_out_rgb[23:19], w_out_rgb[15:10], w_out_rgb[7:3]};
    assign w_unused_lsbs = ^{w_out_rgb[18:16], w_out_rgb[9:8], w_out_rgb[2:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= SYNC_WAIT;
            r_vsync_d  <= 1'b0;
            r_de_d     <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_wr_en    <= 1'b0;
            r_pixel    <= '0;
            r_fsp      <= 1'b0;
            r_overflow <= 1'b0;
            r_line_err <= 1'b0;
        end else begin
            r_vsync_d <= vid.vsync;
            // Masking de on a frame restart keeps a stale run from ending line 0 early.
            r_de_d    <= vid.de & ~w_vsync_fall;
            r_fsp     <= w_vsync_fall;
            r_wr_en   <= 1'b0;

            if (w_vsync_fall) begin
                r_state <= ACTIVE;
                r_x     <= '0;
                r_y     <= '0;
            end else if (r_state == ACTIVE) begin
                if (r_y >= C_V_MAX) begin
                    r_state <= SYNC_WAIT;
                end else if (vid.de) begin
                    if (w_pix_accept) begin
                        r_x <= r_x + 10'd1;
                        if (w_slot) begin
                            if (vid.fifo_full) begin
                                r_overflow <= 1'b1;
                            end else begin
                                r_wr_en <= 1'b1;
                                r_pixel <= w_packed;
                            end
                        end
                    end else begin
                        r_line_err <= 1'b1;
                    end
                end else if (r_de_d) begin
                    if (r_x != C_H_MAX) begin
                        r_line_err <= 1'b1;
                    end
                    r_x <= '0;
                    r_y <= r_y + 9'd1;
                end
            end
        end
    end

    assign vid.pixel_data    = r_pixel;
    assign vid.wr_enable     = r_wr_en;
    assign frame_start_pulse = r_fsp;
    assign o_x_count         = r_x;
    assign o_y_count         = r_y;
    assign overflow          = r_overflow;
    assign line_err          = r_line_err;
endmodule
`default_nettype wire

// File: tb/tb_video_capture_downscaler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_video_capture_downscaler
// Purpose  : Self-checking bench for video_capture_downscaler on a reduced
//            16x8 frame; table-driven frames plus hand-written corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_video_capture_downscaler;
    localparam int H    = 16;
    localparam int V    = 8;
    localparam int MAXW = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    video_capture_downscaler_if vif();
    logic       fsp;
    logic [9:0] xc;
    logic [8:0] yc;
    logic       ovf;
    logic       lerr;

    video_capture_downscaler #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .clk               (clk),
        .rst               (rst),
        .vid               (vif.slave),
        .frame_start_pulse (fsp),
        .o_x_count         (xc),
        .o_y_count         (yc),
        .overflow          (ovf),
        .line_err          (lerr)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    logic [23:0] pix  [V][MAXW];
    int          len  [V];
    bit          full [V][MAXW];
    logic [15:0] expq [$];
    bit          slot_now = 1'b0;
    bit          slot_q   = 1'b0;
    bit          armed    = 1'b0;
    int          wr_cnt   = 0;
    int          fsp_cnt  = 0;
    logic [15:0] last_pix = '0;

    typedef struct {
        bit          do_reset;
        int          mode;      // 0 const, 1 block pattern, 2 random
        int          mod_line;
        int          mod_len;
        int          n_full;    // blocked slots on line 1
        int          exp_wr;
        bit          exp_ovf;
        bit          exp_lerr;
        logic [15:0] exp_pix;
    } vec_t;
    vec_t tbl [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int ch(input logic [23:0] p, input int c);
        return int'((p >> (8 * (2 - c))) & 24'hFF);
    endfunction

    // Reference output pixel for the block whose bottom-right pixel is (y,x).
    function automatic logic [15:0] model(input int y, input int x);
        int s [3];
        for (int c = 0; c < 3; c++) begin
`ifdef BOX_FILTER_EN
            s[c] = (ch(pix[y-1][x-1], c) + ch(pix[y-1][x], c)
                  + ch(pix[y][x-1], c) + ch(pix[y][x], c)) / 4;
`else
            s[c] = ch(pix[y][x], c);
`endif
        end
        return {5'(s[0] / 8), 6'(s[1] / 4), 5'(s[2] / 8)};
    endfunction

    always @(posedge clk) slot_q <= slot_now;

    always @(negedge clk) begin
        if (fsp) fsp_cnt++;
        if (vif.wr_enable) begin
            wr_cnt++;
            last_pix = vif.pixel_data;
        end
        if (slot_q || vif.wr_enable) begin
            check("wr_timing", {31'd0, vif.wr_enable}, {31'd0, slot_q});
            if (vif.wr_enable && slot_q && expq.size() > 0)
                check("pixel", {16'd0, vif.pixel_data}, {16'd0, expq.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        vif.de = 1'b0;
        vif.fifo_full = 1'b0;
        slot_now = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        armed = 1'b0;
        slot_now = 1'b0;
        expq.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic vsync_edge();
        idle(1);
        vif.vsync = 1'b0;
        tick();
        armed = 1'b1;
        tick();
        vif.vsync = 1'b1;
        idle(2);
    endtask

    task automatic drive_line(input int y);
        for (int x = 0; x < len[y]; x++) begin
            vif.de = 1'b1;
            vif.rgb_data = pix[y][x];
            vif.fifo_full = full[y][x];
            slot_now = armed && (y % 2 == 1) && (x % 2 == 1) && (x < H) && !full[y][x];
            if (slot_now) expq.push_back(model(y, x));
            tick();
        end
        idle(3);
    endtask

    task automatic fill(input int mode);
        for (int y = 0; y < V; y++) begin
            len[y] = H;
            for (int x = 0; x < MAXW; x++) begin
                logic [7:0] v;
                full[y][x] = 1'b0;
                case (mode)
                    0:       pix[y][x] = 24'hFF8040;
                    1: begin
                        v = (y % 2 == 0) ? ((x % 2 == 0) ? 8'h10 : 8'h20)
                                         : ((x % 2 == 0) ? 8'h30 : 8'h40);
                        pix[y][x] = {v, v, v};
                    end
                    default: pix[y][x] = 24'($urandom);
                endcase
            end
        end
    endtask

    task automatic run_frame();
        vsync_edge();
        for (int y = 0; y < V; y++) drive_line(y);
        idle(4);
    endtask

    initial begin
        int wr0;
        int f0;
        vif.vsync = 1'b1;
        vif.de = 1'b0;
        vif.rgb_data = '0;
        vif.fifo_full = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_pixel", {16'd0, vif.pixel_data}, 32'd0);
        check("rst_wr", {31'd0, vif.wr_enable}, 32'd0);
        check("rst_fsp", {31'd0, fsp}, 32'd0);
        check("rst_x", {22'd0, xc}, 32'd0);
        check("rst_y", {23'd0, yc}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_lerr", {31'd0, lerr}, 32'd0);
        rst = 1'b0;
        tick();

        // de activity with no vsync edge yet
        fill(2);
        wr0 = wr_cnt;
        for (int y = 0; y < 4; y++) drive_line(y);
        check("pre_vsync_writes", wr_cnt - wr0, 0);
        check("pre_vsync_fsp", fsp_cnt, 0);

        tbl[0] = '{1'b1, 0, 0, H, 0, 32, 1'b0, 1'b0, 16'hFC08};
`ifdef BOX_FILTER_EN
        tbl[1] = '{1'b0, 1, 0, H, 0, 32, 1'b0, 1'b0, 16'h2945};
`else
        tbl[1] = '{1'b0, 1, 0, H, 0, 32, 1'b0, 1'b0, 16'h4208};
`endif
        tbl[2] = '{1'b0, 2, 0, H, 3, 29, 1'b1, 1'b0, 16'h0};
        tbl[3] = '{1'b0, 2, 0, H, 0, 32, 1'b1, 1'b0, 16'h0};
        tbl[4] = '{1'b1, 2, 3, 12, 0, 30, 1'b0, 1'b1, 16'h0};
        tbl[5] = '{1'b0, 2, 5, 20, 0, 32, 1'b0, 1'b1, 16'h0};
        tbl[6] = '{1'b1, 2, 0, H, 0, 32, 1'b0, 1'b0, 16'h0};

        for (int i = 0; i < 7; i++) begin
            if (tbl[i].do_reset) apply_reset();
            fill(tbl[i].mode);
            len[tbl[i].mod_line] = tbl[i].mod_len;
            for (int k = 0; k < tbl[i].n_full; k++) full[1][2*k+1] = 1'b1;
            wr0 = wr_cnt;
            f0 = fsp_cnt;
            run_frame();
            check($sformatf("v%0d_writes", i), wr_cnt - wr0, tbl[i].exp_wr);
            check($sformatf("v%0d_fsp", i), fsp_cnt - f0, 1);
            check($sformatf("v%0d_ovf", i), {31'd0, ovf}, {31'd0, tbl[i].exp_ovf});
            check($sformatf("v%0d_lerr", i), {31'd0, lerr}, {31'd0, tbl[i].exp_lerr});
            check($sformatf("v%0d_y_end", i), {23'd0, yc}, V);
            if (tbl[i].mode != 2)
                check($sformatf("v%0d_pix", i), {16'd0, last_pix}, {16'd0, tbl[i].exp_pix});
        end

        // Reset mid-frame, then no capture until a fresh vsync edge
        apply_reset();
        fill(2);
        full[1][1] = 1'b1;
        vsync_edge();
        for (int y = 0; y < 5; y++) drive_line(y);
        check("mid_ovf_before", {31'd0, ovf}, 32'd1);
        #2;
        rst = 1'b1;
        armed = 1'b0;
        expq.delete();
        #1;
        check("mid_rst_pixel", {16'd0, vif.pixel_data}, 32'd0);
        check("mid_rst_y", {23'd0, yc}, 32'd0);
        check("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        fill(2);
        wr0 = wr_cnt;
        for (int y = 0; y < 4; y++) drive_line(y);
        check("post_rst_writes", wr_cnt - wr0, 0);
        wr0 = wr_cnt;
        run_frame();
        check("post_rst_frame_writes", wr_cnt - wr0, 32);

        // Back-to-back frames
        wr0 = wr_cnt;
        f0 = fsp_cnt;
        fill(2);
        run_frame();
        check("b2b_x_restart", {22'd0, xc}, 32'd0);
        fill(2);
        run_frame();
        check("b2b_writes", wr_cnt - wr0, 64);
        check("b2b_fsp", fsp_cnt - f0, 2);

        // vsync edge mid-frame restarts counting
        wr0 = wr_cnt;
        f0 = fsp_cnt;
        fill(2);
        vsync_edge();
        for (int y = 0; y < 4; y++) drive_line(y);
        check("restart_y_mid", {23'd0, yc}, 32'd4);
        fill(2);
        run_frame();
        check("restart_writes", wr_cnt - wr0, 48);
        check("restart_fsp", fsp_cnt - f0, 2);
        check("restart_queue_drained", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/video_capture_downscaler.md
# video_capture_downscaler

Receive-side counterpart of the HDMI video timing generator. Accepts a 640x480 RGB888 pixel stream qualified by `vsync`/`de` and reduces it 2x in each direction to 320x240. Packs each output pixel to RGB565 and issues FIFO writes toward the AXI writer, which stores the frame in DDR. The block completes the DDR-to-HDMI loop: it produces the frame format that the AXI reader and timing generator consume.

## Interface
Parameters:
- `H_ACTIVE`, 640, active pixels per line; must be even.
- `V_ACTIVE`, 480, active lines per frame; must be even.

Ports:
- `clk`  in  1  pixel clock; single clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `vsync`  in  1  vertical sync, active-low; the falling edge marks frame start.
- `de`  in  1  data enable; high for each active pixel.
- `rgb_data`  in  24  pixel `{R[7:0], G[7:0], B[7:0]}`, valid when `de`=1.
- `fifo_full`  in  1  downstream FIFO full.
- `pixel_data`  out  16  RGB565 `{R[4:0], G[5:0], B[4:0]}`, registered.
- `wr_enable`  out  1  FIFO write strobe; one cycle per output pixel.
- `frame_start_pulse`  out  1  one-cycle pulse on a detected `vsync` falling edge.
- `o_x_count`  out  10  debug: input column counter.
- `o_y_count`  out  9  debug: input line counter.
- `overflow`  out  1  sticky; a write was dropped because `fifo_full` was high.
- `line_err`  out  1  sticky; a line had a `de` run length different from `H_ACTIVE`.

## Operation
- **Reset values.** `rst` forces every output to 0, the state to `SYNC_WAIT`, and both counters to 0. The sticky flags clear only on `rst`.
- **State machine.**
  - `SYNC_WAIT`: `de` is ignored. On a `vsync` falling edge (`vsync_d`=1, `vsync`=0): go to `ACTIVE`, clear x and y, pulse `frame_start_pulse`.
  - `ACTIVE`: counts pixels. Returns to `SYNC_WAIT` once y reaches `V_ACTIVE`. Another `vsync` falling edge while in `ACTIVE` restarts the frame: counters clear and `frame_start_pulse` fires.
- **Column counter x.** Increments on each `de`=1 cycle and saturates at `H_ACTIVE`. Pixels arriving with x=`H_ACTIVE` are dropped and set `line_err`.
- **End of line.** A `de` falling edge (`de_d`=1, `de`=0) sets `line_err` if x≠`H_ACTIVE`, clears x, and increments y.
- **Write slot.** A write slot is any `de`=1 cycle with y[0]=1, x[0]=1, x<`H_ACTIVE`, y<`V_ACTIVE`. This gives `H_ACTIVE`/2 slots on each odd line and `H_ACTIVE*V_ACTIVE/4` slots per frame (76800 at the default parameters).
- **Slot blocked.** If `fifo_full`=1 in a write slot, the pixel is dropped, `wr_enable` stays 0, and `overflow` is set.
- **Packing.** RGB888 is truncated to RGB565: `{R[7:3], G[7:2], B[7:3]}`.
- **Simultaneous events.**
  - `vsync` edge and `de` in the same cycle: the edge wins and that pixel is ignored.
  - `rst` mid-frame: all in-flight data is discarded; capture resumes only after the next `vsync` falling edge.

## Timing
- Latency is 1 cycle: a qualifying write slot at cycle N produces `wr_enable`=1 and valid `pixel_data` at N+1.
- `pixel_data` holds its last value whenever `wr_enable`=0.
- `frame_start_pulse` is high for exactly one cycle, the cycle after the edge is sampled.
- `wr_enable` is never high on two consecutive cycles.

## Configuration
- **`BOX_FILTER_EN` defined.** Each output pixel is the 2x2 box average of its block.
  - On even lines, each odd-x cycle adds the stored even-x pixel to the current pixel per channel. The 9-bit per-channel sums are written into a `H_ACTIVE/2`-entry line buffer (27 bits wide) at address x[9:1].
  - On odd lines, each write slot adds the current pair sum to the buffer entry, giving 10 bits per channel.
  - The result is shifted right by 2, giving 8 bits per channel, then packed to RGB565.
  - A read-before-write at the same address within a cycle is not required.
- **`BOX_FILTER_EN` undefined.** Plain decimation: the output is the bottom-right pixel of each block, i.e. the write-slot pixel itself. No line buffer or pair register is instantiated. Write timing and count are identical to the filtered build.

## Test plan
- Reset, then a 640x480 frame with constant `rgb_data`=0xFF8040 → exactly 76800 `wr_enable` pulses, all `pixel_data`=0xFC08, one `frame_start_pulse`, `overflow`=0, `line_err`=0.
- Each 2x2 block fed with values 0x10/0x20 (row 0) and 0x30/0x40 (row 1) on all channels → 0x2945 with `BOX_FILTER_EN`, 0x4208 without.
- `fifo_full`=1 across 10 write slots on line 1 → 310 writes on that line, `overflow` rises on the first blocked slot and stays 1 through later frames until `rst`.
- Line 3 with 600 `de` cycles → `line_err`=1, 300 writes on that line, y still advances. Line 5 with 700 `de` cycles → 320 writes on that line.
- `de` activity before any `vsync` edge after reset → no writes. `rst` asserted at line 100 → all outputs 0 immediately, no writes until the next `vsync` falling edge.
- Two back-to-back frames → counters restart at 0, one `frame_start_pulse` per frame, and 76800 writes in each frame.
